// File: rtl/idu_ysyx_if.sv
// Instruction-side and execute-side signals of the decode stage, grouped so the
// decoder and whoever drives it see one bundle.
interface idu_ysyx_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_ctr;
    logic        out_alu_asrc;
    logic [1:0]  out_alu_bsrc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
    logic [2:0]  out_funct3;
    logic [2:0]  out_kind;
    logic        out_illegal;

    // Fetch/execute side: drives instructions, flush and out_ready.
    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_alu_ctr, out_alu_asrc,
               out_alu_bsrc, out_rs1, out_rs2, out_rd, out_reg_wen, out_funct3,
               out_kind, out_illegal
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_alu_ctr, out_alu_asrc,
               out_alu_bsrc, out_rs1, out_rs2, out_rd, out_reg_wen, out_funct3,
               out_kind, out_illegal
    );
endinterface

// File: rtl/idu_ysyx.sv
// Single-entry registered RV32I decode stage: decodes the accepted instruction
// into ALU control, operand selects, register indices and a sign-extended immediate.
module idu_ysyx (
    input  logic     clk,
    input  logic     rst_n,
    idu_ysyx_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [1:0] BSRC_RS2 = 2'b00;
    localparam logic [1:0] BSRC_IMM = 2'b01;
    localparam logic [1:0] BSRC_4   = 2'b10;

    localparam logic [2:0] KIND_ALU    = 3'd0;
    localparam logic [2:0] KIND_BRANCH = 3'd1;
    localparam logic [2:0] KIND_JAL    = 3'd2;
    localparam logic [2:0] KIND_JALR   = 3'd3;
    localparam logic [2:0] KIND_LOAD   = 3'd4;
    localparam logic [2:0] KIND_STORE  = 3'd5;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready = !out_valid || out_ready, so the single entry can be replaced in
    // the same cycle it drains; out_valid never depends on out_ready combinationally.
    logic accept;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // alt selects sub (funct3 000) or sra (funct3 101).
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [3:0] c;
        case (f3)
            3'b000:  c = alt ? ALU_SUB : ALU_ADD;
            3'b001:  c = 4'b0001;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = 4'b0100;
            3'b101:  c = alt ? 4'b1101 : 4'b0101;
            3'b110:  c = 4'b0110;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    logic [31:0] d_imm;
    logic [3:0]  d_ctr;
    logic        d_asrc;
    logic [1:0]  d_bsrc;
    logic        d_wen;
    logic [2:0]  d_kind;
    logic        d_illegal;

    always_comb begin
        d_imm     = 32'h0;
        d_ctr     = ALU_ADD;
        d_asrc    = 1'b0;
        d_bsrc    = BSRC_RS2;
        d_wen     = 1'b0;
        d_kind    = KIND_ALU;
        d_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_imm  = imm_u;
                d_ctr  = ALU_PASS;
                d_bsrc = BSRC_IMM;
                d_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                d_imm  = imm_u;
                d_asrc = 1'b1;
                d_bsrc = BSRC_IMM;
                d_wen  = 1'b1;
            end
            OPC_JAL: begin
                d_imm  = imm_j;
                d_asrc = 1'b1;
                d_bsrc = BSRC_4;
                d_wen  = 1'b1;
                d_kind = KIND_JAL;
            end
            OPC_JALR: begin
                d_imm     = imm_i;
                d_asrc    = 1'b1;
                d_bsrc    = BSRC_4;
                d_wen     = 1'b1;
                d_kind    = KIND_JALR;
                d_illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_imm  = imm_b;
                d_kind = KIND_BRANCH;
                case (funct3[2:1])
                    2'b00:   d_ctr = ALU_SUB;
                    2'b10:   d_ctr = ALU_SLT;
                    2'b11:   d_ctr = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_imm     = imm_i;
                d_bsrc    = BSRC_IMM;
                d_wen     = 1'b1;
                d_kind    = KIND_LOAD;
                d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                d_imm     = imm_s;
                d_bsrc    = BSRC_IMM;
                d_kind    = KIND_STORE;
                d_illegal = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                d_imm  = imm_i;
                d_bsrc = BSRC_IMM;
                d_wen  = 1'b1;
                d_ctr  = alu_code(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    d_illegal = (funct7 != 7'h00);
                else if (funct3 == 3'b101)
                    d_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP: begin
                d_wen     = 1'b1;
                d_ctr     = alu_code(funct3, funct7[5]);
                d_illegal = !((funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: d_illegal = 1'b1;
        endcase
        // Illegal instructions carry no side effects downstream.
        if (d_illegal) begin
            d_imm  = 32'h0;
            d_ctr  = ALU_ADD;
            d_asrc = 1'b0;
            d_bsrc = BSRC_RS2;
            d_wen  = 1'b0;
            d_kind = KIND_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= 32'h0;
            bus.out_imm      <= 32'h0;
            bus.out_alu_ctr  <= 4'h0;
            bus.out_alu_asrc <= 1'b0;
            bus.out_alu_bsrc <= 2'b00;
            bus.out_rs1      <= 5'd0;
            bus.out_rs2      <= 5'd0;
            bus.out_rd       <= 5'd0;
            bus.out_reg_wen  <= 1'b0;
            bus.out_funct3   <= 3'd0;
            bus.out_kind     <= 3'd0;
            bus.out_illegal  <= 1'b0;
        end else begin
            if (bus.flush)
                bus.out_valid <= 1'b0;
            else if (accept)
                bus.out_valid <= 1'b1;
            else if (bus.out_ready)
                bus.out_valid <= 1'b0;

            if (accept && !bus.flush) begin
                bus.out_pc       <= bus.in_pc;
                bus.out_imm      <= d_imm;
                bus.out_alu_ctr  <= d_ctr;
                bus.out_alu_asrc <= d_asrc;
                bus.out_alu_bsrc <= d_bsrc;
                bus.out_rs1      <= inst[19:15];
                bus.out_rs2      <= inst[24:20];
                bus.out_rd       <= inst[11:7];
                bus.out_reg_wen  <= d_wen;
                bus.out_funct3   <= funct3;
                bus.out_kind     <= d_kind;
                bus.out_illegal  <= d_illegal;
            end
        end
    end
endmodule

// File: tb/tb_idu_ysyx.sv
// Bench for idu_ysyx: directed literal checks plus randomized traffic compared
// every cycle against a queue-based reference of the decode stage.
module tb_idu_ysyx;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  ctr;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  f3;
    logic [2:0]  kind;
    logic        illegal;
  } dec_t;
  localparam int W = $bits(dec_t);

  logic clk;
  logic rst_n;
  int tests;
  int fails;
  logic [W-1:0] exp_q[$];
  dec_t act;

  idu_ysyx_if bus ();
  idu_ysyx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign act = {bus.out_pc, bus.out_imm, bus.out_alu_ctr, bus.out_alu_asrc, bus.out_alu_bsrc,
                bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_reg_wen, bus.out_funct3,
                bus.out_kind, bus.out_illegal};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // reference decode, written from the ISA tables
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input bit alt);
    logic [3:0] tab [8];
    tab = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7};
    if (alt && f3 == 3'd0) return 4'h8;
    if (alt && f3 == 3'd5) return 4'hD;
    return tab[f3];
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    dec_t d;
    bit legal;
    int f3, f7;
    int ii, ss, bb, jj;
    d = '0;
    d.pc = pc;
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    d.rd = inst[11:7];
    d.f3 = inst[14:12];
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    ii = $signed(inst) >>> 20;
    ss = (ii & ~32'h1F) | int'(inst[11:7]);
    bb = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    jj = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
    legal = 1;
    case (inst[6:0])
      7'h37: begin d.ctr = 4'h3; d.bsrc = 2'd1; d.wen = 1; d.imm = inst & 32'hFFFFF000; end
      7'h17: begin d.asrc = 1; d.bsrc = 2'd1; d.wen = 1; d.imm = inst & 32'hFFFFF000; end
      7'h6F: begin d.asrc = 1; d.bsrc = 2'd2; d.wen = 1; d.kind = 3'd2; d.imm = jj; end
      7'h67: begin d.asrc = 1; d.bsrc = 2'd2; d.wen = 1; d.kind = 3'd3; d.imm = ii; legal = (f3 == 0); end
      7'h63: begin
        d.kind = 3'd1; d.imm = bb;
        legal = (f3 != 2 && f3 != 3);
        d.ctr = (f3 < 2) ? 4'h8 : (f3 < 6) ? 4'h2 : 4'hA;
      end
      7'h03: begin d.bsrc = 2'd1; d.wen = 1; d.kind = 3'd4; d.imm = ii; legal = (f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin d.bsrc = 2'd1; d.kind = 3'd5; d.imm = ss; legal = (f3 < 3); end
      7'h13: begin
        d.bsrc = 2'd1; d.wen = 1; d.imm = ii;
        d.ctr = ref_alu(inst[14:12], f3 == 5 && f7 == 32);
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0 || f7 == 32);
      end
      7'h33: begin
        d.wen = 1;
        d.ctr = ref_alu(inst[14:12], f7 == 32);
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      d.imm = 0; d.ctr = 0; d.asrc = 0; d.bsrc = 0; d.wen = 0; d.kind = 0;
      d.illegal = 1;
    end
    return d;
  endfunction

  // reference stage: the queue holds the single entry visible at the outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      bit acc;
      acc = bus.in_valid && (exp_q.size() == 0 || bus.out_ready);
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_decode(bus.in_inst, bus.in_pc));
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("in_ready", W'(bus.in_ready), W'(exp_q.size() == 0 || bus.out_ready));
    chk("out_valid", W'(bus.out_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("entry", act, exp_q[0]);
  end

  // driver tasks
  task automatic idle();
    bus.in_valid = 0;
    bus.in_inst = 0;
    bus.in_pc = 0;
    bus.flush = 0;
    bus.out_ready = 1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    @(posedge clk); #1;
    bus.in_valid = 1;
    bus.in_inst = inst;
    bus.in_pc = pc;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [10];
    logic [6:0] f7;
    int r;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    if ($urandom_range(0, 19) == 0) return $urandom;
    r = $urandom_range(0, 9);
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: f7 = 7'h00;
      5, 6, 7:       f7 = 7'h20;
      default:       f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opcs[r]};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 0;
    idle();
    #22 rst_n = 1;
    @(negedge clk);
    chk("reset_valid", W'(bus.out_valid), W'(0));
    chk("reset_regs", act, '0);

    send(32'h00500093, 32'h80000000);
    chk("addi_valid", W'(bus.out_valid), W'(1));
    chk("addi_pc", W'(bus.out_pc), W'(32'h80000000));
    chk("addi_ctr", W'(bus.out_alu_ctr), W'(4'b0000));
    chk("addi_asrc", W'(bus.out_alu_asrc), W'(0));
    chk("addi_bsrc", W'(bus.out_alu_bsrc), W'(2'b01));
    chk("addi_imm", W'(bus.out_imm), W'(32'h5));
    chk("addi_rd", W'(bus.out_rd), W'(1));
    chk("addi_wen", W'(bus.out_reg_wen), W'(1));

    send(32'h402081B3, 32'h80000004);
    chk("sub_ctr", W'(bus.out_alu_ctr), W'(4'b1000));
    chk("sub_bsrc", W'(bus.out_alu_bsrc), W'(2'b00));
    chk("sub_rs1", W'(bus.out_rs1), W'(1));
    chk("sub_rs2", W'(bus.out_rs2), W'(2));
    chk("sub_rd", W'(bus.out_rd), W'(3));

    send(32'h40335293, 32'h80000008);
    chk("srai_ctr", W'(bus.out_alu_ctr), W'(4'b1101));
    chk("srai_imm", W'(bus.out_imm), W'(32'h403));

    send(32'h0020E463, 32'h8000000C);
    chk("bltu_kind", W'(bus.out_kind), W'(1));
    chk("bltu_ctr", W'(bus.out_alu_ctr), W'(4'b1010));
    chk("bltu_imm", W'(bus.out_imm), W'(32'h8));
    chk("bltu_wen", W'(bus.out_reg_wen), W'(0));

    // back-pressure, then drain and accept in one edge
    @(posedge clk); #1;
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.in_inst = 32'h00500093;
    bus.in_pc = 32'h100;
    @(posedge clk); #1;
    bus.in_inst = 32'h402081B3;
    bus.in_pc = 32'h104;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", W'(bus.in_ready), W'(0));
      chk("stall_pc", W'(bus.out_pc), W'(32'h100));
      chk("stall_imm", W'(bus.out_imm), W'(32'h5));
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("drain_valid", W'(bus.out_valid), W'(1));
    chk("drain_pc", W'(bus.out_pc), W'(32'h104));
    chk("drain_ctr", W'(bus.out_alu_ctr), W'(4'b1000));

    send(32'hFFFFFFFF, 32'h200);
    chk("ill_flag", W'(bus.out_illegal), W'(1));
    chk("ill_wen", W'(bus.out_reg_wen), W'(0));
    chk("ill_kind", W'(bus.out_kind), W'(0));
    bus.out_ready = 0;
    @(posedge clk); #1;
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    @(negedge clk);
    chk("flush_valid", W'(bus.out_valid), W'(0));
    // flush with a same-cycle accept
    @(posedge clk); #1;
    bus.out_ready = 1;
    bus.flush = 1;
    bus.in_valid = 1;
    bus.in_inst = 32'h00500093;
    @(posedge clk); #1;
    bus.flush = 0;
    bus.in_valid = 0;
    @(negedge clk);
    chk("flush_drop", W'(bus.out_valid), W'(0));

    // asynchronous reset between edges
    bus.out_ready = 0;
    send(32'h00500093, 32'h300);
    chk("pre_rst_valid", W'(bus.out_valid), W'(1));
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_valid", W'(bus.out_valid), W'(0));
    chk("arst_regs", act, '0);
    @(posedge clk); #3;
    rst_n = 1;
    bus.out_ready = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_inst = rand_inst();
      bus.in_pc = $urandom & 32'hFFFFFFFC;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/idu_ysyx.md
IDU_YSYX -- requirements
Module: idu_ysyx

Interface
REQ-001 The module SHALL have these ports: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 The module SHALL have these ports: in_valid in 1 / in_ready out 1, the instruction-side handshake.
REQ-004 The module SHALL have these ports: in_inst in 32, the instruction; in_pc in 32, its PC.
REQ-005 The module SHALL have these ports: flush in 1, which drops the held entry.
REQ-006 The module SHALL have these ports: out_valid out 1 / out_ready in 1, the execute-side handshake.
REQ-007 The module SHALL have these ports: out_pc out 32; out_imm out 32, the sign-extended immediate.
REQ-008 The module SHALL have these ports: out_alu_ctr out 4; out_alu_asrc out 1 (1=pc, 0=rs1); out_alu_bsrc out 2 (00 rs2, 01 imm, 10 const 4).
REQ-009 The module SHALL have these ports: out_rs1, out_rs2, out_rd, each out 5; out_reg_wen out 1; out_funct3 out 3.
REQ-010 The module SHALL have these ports: out_kind out 3 (0 alu, 1 branch, 2 jal, 3 jalr, 4 load, 5 store); out_illegal out 1.

Function
REQ-011 The module SHALL be a single-entry registered decode stage; every out_* except out_valid SHALL come from a register loaded only on an accept (in_valid && in_ready).
REQ-012 in_ready SHALL equal !out_valid || out_ready, computed combinationally; there is no skid buffer.
REQ-013 After an accept, out_valid SHALL be 1 in the next cycle (latency 1); out_valid SHALL fall only when out_ready=1 and no new accept occurs in the same cycle.
REQ-014 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-015 A simultaneous drain and accept SHALL load the new entry with no bubble cycle.
REQ-016 flush=1 SHALL clear out_valid at the next edge, and SHALL discard any same-cycle accept; in_ready is unaffected by flush.
REQ-017 ALU codes SHALL be: add 0000, sub 1000, lui/pass-B 0011, slt 0010, sltu 1010, xor 0100, or 0110, and 0111, sll 0001, srl 0101, sra 1101.
REQ-018 OP and OP-IMM SHALL map by funct3; funct7[5] SHALL select sub (OP only) and sra; asrc=0; bsrc=00 for OP, 01 for OP-IMM; reg_wen=1.
REQ-019 The following SHALL use add: lui as ctr 0011, bsrc 01; auipc as asrc 1, bsrc 01; jal/jalr as asrc 1, bsrc 10, reg_wen 1; load/store as asrc 0, bsrc 01, with reg_wen 1 for loads and 0 for stores.
REQ-020 Branches SHALL use asrc 0, bsrc 00, and reg_wen 0; beq/bne SHALL use 1000, blt/bge 0010, bltu/bgeu 1010.
REQ-021 Immediates SHALL be I, S, B (bit0=0), U (low 12 zero), or J (bit0=0), each sign-extended from inst[31]; R-type SHALL give imm 0.
REQ-022 Unknown opcode, or invalid funct3/funct7 (e.g. OP funct7 not 0x00/0x20, slli funct7!=0), SHALL give out_illegal=1, reg_wen=0, ctr 0000, kind 0.
REQ-023 rd SHALL be reported as decoded even when it is x0; reg_wen SHALL NOT be suppressed for rd=0.

Reset
REQ-024 When rst_n=0, out_valid SHALL go to 0 immediately, regardless of clk.
REQ-025 When rst_n=0, all registered out_* SHALL be 0 (ctr 0000, bsrc 00, imm 0, illegal 0).
REQ-026 Reset SHALL discard any held entry; the first accept SHALL occur at the first edge with rst_n=1 and in_valid=1.

Verification
REQ-027 The bench SHALL check: 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> next cycle out_valid=1, ctr 0000, asrc 0, bsrc 01, imm 0x00000005, rd 1, reg_wen 1.
REQ-028 The bench SHALL check: 0x402081B3 (sub x3,x1,x2) -> ctr 1000, bsrc 00, rs1 1, rs2 2, rd 3; 0x40335293 (srai x5,x6,3) -> ctr 1101, imm 0x00000403.
REQ-029 The bench SHALL check: 0x0020E463 (bltu x1,x2,+8) -> kind 1, ctr 1010, imm 0x00000008, reg_wen 0.
REQ-030 The bench SHALL check: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> drain and accept in the same cycle.
REQ-031 The bench SHALL check: 0xFFFFFFFF -> out_illegal=1, reg_wen 0; flush with out_valid=1 -> out_valid=0 the next cycle.
REQ-032 The bench SHALL check: rst_n pulsed low between edges while out_valid=1 -> out_valid=0 at once and all outputs 0.
